// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencer and its counter datapath.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } seq_state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_RWIDTH = 4;

endpackage

// File: rtl/mod_counter.sv
// Modulo 0..modv up/down counter register; wrap flags that the next enabled step
// would roll over to the opposite end of the range.
module mod_counter
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [WIDTH-1:0] modv,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] r_count;

  assign wrap  = (dir == DIR_DOWN) ? (r_count == '0) : (r_count == modv);
  assign count = r_count;

  // Load has priority over stepping so the sequencer can preset or clear mid-run.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en) begin
      if (wrap) begin
        r_count <= (dir == DIR_DOWN) ? modv : '0;
      end else if (dir == DIR_DOWN) begin
        r_count <= r_count - WIDTH'(1);
      end else begin
        r_count <= r_count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Run sequencer for the modulo counter: latches a command, steps through the
// requested number of rounds, and supports pause/abort with registered status.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int RWIDTH = DEF_RWIDTH
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  input  logic              dir,
  input  logic [WIDTH-1:0]  modv,
  input  logic [RWIDTH-1:0] rounds,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              tc,
  output logic              done,
  output logic [RWIDTH-1:0] rnd
);

  seq_state_e        r_state;
  seq_state_e        w_next;
  logic              r_dir;
  logic [WIDTH-1:0]  r_modv;
  logic [RWIDTH-1:0] r_rounds;
  logic [RWIDTH-1:0] r_rnd;
  logic [RWIDTH-1:0] w_rndNext;
  logic              r_busy;
  logic              r_tc;
  logic              r_done;
  logic              w_en;
  logic              w_load;
  logic [WIDTH-1:0]  w_loadVal;
  logic              w_latch;
  logic              w_wrap;

  mod_counter #(.WIDTH(WIDTH)) u_counter (
    .clk      (clk),
    .clr      (clr),
    .en       (w_en),
    .load     (w_load),
    .load_val (w_loadVal),
    .dir      (r_dir),
    .modv     (r_modv),
    .count    (count),
    .wrap     (w_wrap)
  );

  always_ff @(posedge clk) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Abort clears the counter through the load path so IDLE starts from zero.
  always_comb begin
    w_next    = r_state;
    w_en      = 1'b0;
    w_load    = 1'b0;
    w_loadVal = '0;
    w_latch   = 1'b0;
    w_rndNext = r_rnd;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next    = RUN;
          w_load    = 1'b1;
          w_loadVal = (dir == DIR_DOWN) ? modv : '0;
          w_latch   = 1'b1;
          w_rndNext = '0;
        end
      end
      RUN: begin
        if (abort) begin
          w_next    = IDLE;
          w_load    = 1'b1;
          w_rndNext = '0;
        end else if (pause) begin
          w_next = HOLD;
        end else begin
          w_en = 1'b1;
          if (w_wrap) begin
            w_rndNext = r_rnd + RWIDTH'(1);
            if ((r_rounds != '0) && (w_rndNext == r_rounds)) w_next = DONE;
          end
        end
      end
      HOLD: begin
        if (abort) begin
          w_next    = IDLE;
          w_load    = 1'b1;
          w_rndNext = '0;
        end else if (!pause) begin
          w_next = RUN;
        end
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with count.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_dir    <= DIR_UP;
      r_modv   <= '0;
      r_rounds <= '0;
      r_rnd    <= '0;
      r_busy   <= 1'b0;
      r_tc     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_latch) begin
        r_dir    <= dir;
        r_modv   <= modv;
        r_rounds <= rounds;
      end
      r_rnd  <= w_rndNext;
      r_busy <= (w_next == RUN) || (w_next == HOLD);
      r_tc   <= w_en && w_wrap;
      r_done <= (w_next == DONE);
    end
  end

  assign busy = r_busy;
  assign tc   = r_tc;
  assign done = r_done;
  assign rnd  = r_rnd;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed scenarios plus random traffic, checked every cycle against a
// behavioural model of the run sequencer.
module tb_counter_seq_ctrl;

  localparam int WIDTH  = 4;
  localparam int RWIDTH = 4;

  logic              clk = 1'b0;
  logic              clr = 1'b1;
  logic              start = 1'b0;
  logic              pause = 1'b0;
  logic              abort = 1'b0;
  logic              dir = 1'b0;
  logic [WIDTH-1:0]  modv = '0;
  logic [RWIDTH-1:0] rounds = '0;
  logic [WIDTH-1:0]  count;
  logic              busy;
  logic              tc;
  logic              done;
  logic [RWIDTH-1:0] rnd;

  int total = 0;
  int bad   = 0;

  // Reference model state, kept as plain integers and flags.
  bit mActive, mPaused, mFinishing;
  int mCount, mRnd, mDir, mModv, mRounds;
  bit mTc, mDone, mBusy;

  counter_seq_ctrl #(.WIDTH(WIDTH), .RWIDTH(RWIDTH)) dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .pause  (pause),
    .abort  (abort),
    .dir    (dir),
    .modv   (modv),
    .rounds (rounds),
    .count  (count),
    .busy   (busy),
    .tc     (tc),
    .done   (done),
    .rnd    (rnd)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock edge of the run rules, applied to the inputs the DUT just sampled.
  task automatic modelStep();
    int span;
    bit wrapped;
    if (clr) begin
      mActive = 0; mPaused = 0; mFinishing = 0;
      mCount = 0; mRnd = 0; mDir = 0; mModv = 0; mRounds = 0;
      mTc = 0; mDone = 0; mBusy = 0;
      return;
    end
    mTc = 0;
    if (mFinishing) begin
      mFinishing = 0;
    end else if (!mActive) begin
      if (start) begin
        mDir = int'(dir); mModv = int'(modv); mRounds = int'(rounds);
        mCount = mDir ? mModv : 0;
        mRnd = 0; mActive = 1; mPaused = 0;
      end
    end else if (abort) begin
      mCount = 0; mRnd = 0; mActive = 0; mPaused = 0;
    end else if (mPaused) begin
      if (!pause) mPaused = 0;
    end else if (pause) begin
      mPaused = 1;
    end else begin
      span = mModv + 1;
      wrapped = mDir ? (mCount == 0) : (mCount == mModv);
      mCount = mDir ? (mCount + span - 1) % span : (mCount + 1) % span;
      if (wrapped) begin
        mTc = 1;
        mRnd = (mRnd + 1) % (1 << RWIDTH);
        if (mRounds != 0 && mRnd == mRounds) begin
          mActive = 0; mFinishing = 1;
        end
      end
    end
    mBusy = mActive;
    mDone = mFinishing;
  endtask

  task automatic applyStimulus(input bit c, input bit s, input bit p, input bit a,
                               input bit d, input int m, input int r);
    clr = c; start = s; pause = p; abort = a; dir = d;
    modv = WIDTH'(m); rounds = RWIDTH'(r);
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("count", int'(count), mCount);
    checkOutput("busy",  int'(busy),  int'(mBusy));
    checkOutput("tc",    int'(tc),    int'(mTc));
    checkOutput("done",  int'(done),  int'(mDone));
    checkOutput("rnd",   int'(rnd),   mRnd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset, then reset in the middle of a free run, then clr beats start.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 5, 0);
    idle(3);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 3, 1);
    idle(2);

    // Up run, two rounds of 0..3.
    applyStimulus(0, 1, 0, 0, 0, 3, 2);
    idle(11);

    // Down run with a pause at count 3.
    applyStimulus(0, 1, 0, 0, 1, 5, 1);
    idle(2);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
    idle(8);

    // Free run aborted with pause, then an immediate restart.
    applyStimulus(0, 1, 0, 0, 0, 2, 0);
    idle(1);
    applyStimulus(0, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 6, 3);
    idle(4);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    idle(1);

    // modv of zero wraps on every step.
    applyStimulus(0, 1, 0, 0, 0, 0, 4);
    idle(7);

    // Start while busy is ignored.
    applyStimulus(0, 1, 0, 0, 0, 7, 1);
    idle(4);
    applyStimulus(0, 1, 0, 0, 1, 2, 3);
    idle(6);

    // Long free run to exercise rnd rollover.
    applyStimulus(0, 1, 0, 0, 0, 1, 0);
    idle(40);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 5)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
